// File: rtl/stopwatch_counter.sv
// Purpose: run/pause/clear stopwatch timebase; divides core clock to a centisecond tick, cascades ms/sec/min.
// Latency: all outputs registered; counts, o_tick and o_wrap update on the edge that consumes the tick.
// Backpressure: none; pulse inputs are acted on once per high cycle, counts simply free-run while in RUN.
module stopwatch_counter #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_onOff,
  input  logic       i_clear,
  output logic [6:0] o_ms,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic       o_running,
  output logic       o_tick,
  output logic       o_wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic          do_clear;
  logic          advance;
  logic          do_tick;
  logic          ms_last;
  logic          sec_last;
  logic          min_last;

  // Run-state transitions; clear beats on/off outside RUN, on/off beats clear inside RUN.
  always_comb begin
    state_nxt = state;
    do_clear  = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_STOP: begin
        if (i_clear)      do_clear  = 1'b1;
        else if (i_onOff) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // The pausing edge neither ticks nor moves the prescaler, so the fraction survives.
        if (i_onOff) state_nxt = ST_PAUSE;
        else         advance   = 1'b1;
      end
      ST_PAUSE: begin
        if (i_clear) begin
          state_nxt = ST_STOP;
          do_clear  = 1'b1;
        end else if (i_onOff) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  assign do_tick  = advance && (presc == PRE_MAX);
  assign ms_last  = (o_ms  == 7'd99);
  assign sec_last = (o_sec == 6'd59);
  assign min_last = (o_min == 6'd59);

  // State register; o_running mirrors the state being entered so it is glitch-free and registered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_STOP;
      o_running <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_running <= (state_nxt == ST_RUN);
    end
  end

  // Prescaler: advances only while staying in RUN, held in PAUSE, zeroed by an accepted clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc <= '0;
    end else if (do_clear) begin
      presc <= '0;
    end else if (advance) begin
      presc <= do_tick ? '0 : presc + 1'b1;
    end
  end

  // Count cascade with carry plus the one-cycle tick and wrap pulses aligned with the new counts.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ms   <= '0;
      o_sec  <= '0;
      o_min  <= '0;
      o_tick <= 1'b0;
      o_wrap <= 1'b0;
    end else begin
      o_tick <= do_tick;
      o_wrap <= do_tick && ms_last && sec_last && min_last;
      if (do_clear) begin
        o_ms  <= '0;
        o_sec <= '0;
        o_min <= '0;
      end else if (do_tick) begin
        if (ms_last) begin
          o_ms <= '0;
          if (sec_last) begin
            o_sec <= '0;
            o_min <= min_last ? 6'd0 : o_min + 6'd1;
          end else begin
            o_sec <= o_sec + 6'd1;
          end
        end else begin
          o_ms <= o_ms + 7'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose: self-checking bench for stopwatch_counter against a total-centisecond reference model.
// Latency: model is stepped on each rising edge, DUT compared on the following falling edge.
// Backpressure: none; directed scenarios followed by randomized run/pause/clear pulses.
module tb_stopwatch_counter;

  localparam int CLK_HZ  = 10;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int FULL    = 60 * 60 * 100;
  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b1;
  logic       i_onOff = 1'b0;
  logic       i_clear = 1'b0;
  logic [6:0] o_ms;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic       o_running;
  logic       o_tick;
  logic       o_wrap;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: mode, sub-tick fraction and elapsed centiseconds modulo one hour.
  int m_mode = M_STOP;
  int m_pre = 0;
  int m_total = 0;
  int m_tick = 0;
  int m_wrap = 0;

  stopwatch_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_onOff   (i_onOff),
    .i_clear   (i_clear),
    .o_ms      (o_ms),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_running (o_running),
    .o_tick    (o_tick),
    .o_wrap    (o_wrap)
  );

  // 10-unit clock period: rising edges at 5, 15, 25, ...
  always #5 i_clk = ~i_clk;

  // Hard stop in case a directed wait is ever miscoded.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_STOP;
    m_pre   = 0;
    m_total = 0;
    m_tick  = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit on, input bit clr);
    m_tick = 0;
    m_wrap = 0;
    case (m_mode)
      M_STOP: begin
        if (clr) begin
          m_pre   = 0;
          m_total = 0;
        end else if (on) begin
          m_mode = M_RUN;
        end
      end
      M_RUN: begin
        if (on) begin
          m_mode = M_PAUSE;
        end else if (m_pre == DIV - 1) begin
          m_pre   = 0;
          m_total = (m_total + 1) % FULL;
          m_tick  = 1;
          m_wrap  = (m_total == 0) ? 1 : 0;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      default: begin
        if (clr) begin
          m_mode  = M_STOP;
          m_pre   = 0;
          m_total = 0;
        end else if (on) begin
          m_mode = M_RUN;
        end
      end
    endcase
  endtask

  task automatic compare_model();
    check("model_ms",      int'(o_ms),      m_total % 100);
    check("model_sec",     int'(o_sec),     (m_total / 100) % 60);
    check("model_min",     int'(o_min),     m_total / 6000);
    check("model_running", int'(o_running), (m_mode == M_RUN) ? 1 : 0);
    check("model_tick",    int'(o_tick),    m_tick);
    check("model_wrap",    int'(o_wrap),    m_wrap);
  endtask

  // One clock: present pulses, step model at the edge, compare at the falling edge.
  task automatic cycle(input bit on, input bit clr);
    i_onOff = on;
    i_clear = clr;
    @(posedge i_clk);
    model_step(on, clr);
    @(negedge i_clk);
    i_onOff = 1'b0;
    i_clear = 1'b0;
    compare_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  initial begin
    bit found;

    // Reset: assert asynchronously between edges and check outputs before any edge.
    #2 i_reset_n = 1'b0;
    #1;
    check("reset_ms",      int'(o_ms),      0);
    check("reset_sec",     int'(o_sec),     0);
    check("reset_min",     int'(o_min),     0);
    check("reset_running", int'(o_running), 0);
    check("reset_tick",    int'(o_tick),    0);
    check("reset_wrap",    int'(o_wrap),    0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    idle(3);

    // Start: ticks after edges 10, 20, 30 following the on/off edge.
    cycle(1'b1, 1'b0);
    check("start_running", int'(o_running), 1);
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      check("start_tick", int'(o_tick), (k % DIV == 0) ? 1 : 0);
    end
    check("start_ms3", int'(o_ms), 3);
    check("start_sec0", int'(o_sec), 0);

    // Pause/resume: 5 cycles of fraction kept, so resume ticks 5 cycles later.
    idle(15);
    check("pause_pre_ms", int'(o_ms), 4);
    cycle(1'b1, 1'b0);
    idle(50);
    check("paused_ms", int'(o_ms), 4);
    check("paused_running", int'(o_running), 0);
    cycle(1'b1, 1'b0);
    idle(4);
    check("resume_no_tick_yet", int'(o_tick), 0);
    idle(1);
    check("resume_tick_at_5", int'(o_tick), 1);
    check("resume_ms", int'(o_ms), 5);

    // Clear ignored in RUN, honoured in PAUSE, then a full DIV to first tick.
    idle(20);
    check("run_ms7", int'(o_ms), 7);
    cycle(1'b0, 1'b1);
    check("run_clear_ignored_ms", int'(o_ms), 7);
    check("run_clear_ignored_running", int'(o_running), 1);
    cycle(1'b1, 1'b0);
    idle(3);
    cycle(1'b0, 1'b1);
    check("pause_clear_ms", int'(o_ms), 0);
    check("pause_clear_running", int'(o_running), 0);
    cycle(1'b1, 1'b0);
    idle(DIV - 1);
    check("after_clear_no_tick", int'(o_tick), 0);
    idle(1);
    check("after_clear_tick", int'(o_tick), 1);
    check("after_clear_ms", int'(o_ms), 1);

    // Simultaneous pulses: clear wins in PAUSE, on/off wins in RUN.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    check("both_pause_ms", int'(o_ms), 0);
    check("both_pause_running", int'(o_running), 0);
    cycle(1'b1, 1'b0);
    idle(25);
    cycle(1'b1, 1'b1);
    check("both_run_ms", int'(o_ms), 2);
    check("both_run_running", int'(o_running), 0);
    cycle(1'b1, 1'b0);

    // Centisecond carry into seconds without wrap (preset while paused).
    cycle(1'b1, 1'b0);
    @(negedge i_clk);
    force dut.o_ms  = 7'd98;
    force dut.o_sec = 6'd5;
    force dut.o_min = 6'd2;
    #1;
    release dut.o_ms;
    release dut.o_sec;
    release dut.o_min;
    m_total = 2 * 6000 + 5 * 100 + 98;
    cycle(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idle(1);
      if (o_sec == 6'd6) found = 1'b1;
    end
    check("carry_seen", int'(found), 1);
    check("carry_ms", int'(o_ms), 0);
    check("carry_min", int'(o_min), 2);
    check("carry_wrap", int'(o_wrap), 0);

    // Full wrap 59:59.99 -> 00:00.00.
    cycle(1'b1, 1'b0);
    @(negedge i_clk);
    force dut.o_ms  = 7'd97;
    force dut.o_sec = 6'd59;
    force dut.o_min = 6'd59;
    #1;
    release dut.o_ms;
    release dut.o_sec;
    release dut.o_min;
    m_total = FULL - 3;
    cycle(1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      idle(1);
      if (o_wrap) found = 1'b1;
    end
    check("wrap_seen", int'(found), 1);
    check("wrap_ms", int'(o_ms), 0);
    check("wrap_sec", int'(o_sec), 0);
    check("wrap_min", int'(o_min), 0);
    check("wrap_tick", int'(o_tick), 1);
    idle(1);
    check("wrap_one_cycle", int'(o_wrap), 0);

    // Randomized pulses checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom % 40) == 0, ($urandom % 25) == 0);
    end

    // Async reset mid-count with o_sec = 3, asserted between edges.
    if (m_mode == M_RUN) cycle(1'b1, 1'b0);
    if (m_mode == M_STOP) begin
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
    end
    @(negedge i_clk);
    force dut.o_ms  = 7'd40;
    force dut.o_sec = 6'd3;
    force dut.o_min = 6'd0;
    #1;
    release dut.o_ms;
    release dut.o_sec;
    release dut.o_min;
    m_total = 340;
    cycle(1'b1, 1'b0);
    idle(7);
    check("pre_reset_sec", int'(o_sec), 3);
    @(posedge i_clk);
    #3 i_reset_n = 1'b0;
    #1;
    check("arst_ms",      int'(o_ms),      0);
    check("arst_sec",     int'(o_sec),     0);
    check("arst_min",     int'(o_min),     0);
    check("arst_running", int'(o_running), 0);
    check("arst_tick",    int'(o_tick),    0);
    check("arst_wrap",    int'(o_wrap),    0);
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    idle(25);
    check("post_reset_stop_running", int'(o_running), 0);
    check("post_reset_stop_ms", int'(o_ms), 0);
    cycle(1'b1, 1'b0);
    check("post_reset_start", int'(o_running), 1);
    idle(DIV);
    check("post_reset_first_tick_ms", int'(o_ms), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
